switch_debounce_ctrl: RTL and testbench

//   Multi-channel debounce controller that shares one prescaler and one scan

---
 rtl/switch_debounce_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_switch_debounce_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : switch_debounce_ctrl                                            |
// | Brief  : Multi-channel switch debouncer with a shared prescaler, a       |
// |          round-robin scan sequencer and a valid/ready change-event FIFO. |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module switch_debounce_ctrl #(
  parameter int NUM_CH       = 4,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 16,
  parameter int EVT_DEPTH    = 4,
  localparam int CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] switch_in,
  output logic [NUM_CH-1:0] switch_out,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [CHW-1:0]    event_ch,
  output logic              event_level,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int AW = $clog2(EVT_DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [PW-1:0]     r_presc;
  logic              w_tick;
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  logic [0:0]        r_state;
  logic [CHW-1:0]    r_idx;
  logic [NUM_CH-1:0] w_accept;
  logic              w_push;
  logic              w_push_lvl;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= switch_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state <= S_SCAN;
            r_idx   <= '0;
          end
        end
        S_SCAN: begin
          if (r_idx == CHW'(NUM_CH - 1)) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + CHW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Each channel owns its qualification counter; only the scanned one moves.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic          r_out;
    logic          w_hit;
    logic          w_diff;

    assign w_hit       = (r_state == S_SCAN) && (r_idx == CHW'(i));
    assign w_diff      = r_sync2[i] ^ r_out;
    assign w_accept[i] = w_hit && w_diff && (r_cnt == CW'(STABLE_TICKS - 1));
    assign switch_out[i] = r_out;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
        r_out <= 1'b0;
      end else if (w_hit) begin
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (r_cnt != CW'(STABLE_TICKS - 1)) begin
          r_cnt <= r_cnt + CW'(1);
        end else begin
          r_out <= r_sync2[i];
          r_cnt <= '0;
        end
      end
    end
  end

  // At most one channel is scanned per cycle, so the accepted level is unique.
  assign w_push     = |w_accept;
  assign w_push_lvl = |(w_accept & r_sync2);

  logic [CHW:0] r_mem [EVT_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;
  logic          w_drop;
  logic          r_ovf;

  assign w_pop  = (r_count != '0) && event_ready;
  assign w_full = (r_count == (AW + 1)'(EVT_DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= {r_idx, w_push_lvl};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + (AW + 1)'(1);
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clear_overflow) begin
      r_ovf <= 1'b0;
    end
  end

  assign event_valid              = (r_count != '0);
  assign {event_ch, event_level}  = event_valid ? r_mem[r_rptr] : '0;
  assign overflow                 = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_switch_debounce_ctrl                                         |
// | Brief  : Directed + random bench for switch_debounce_ctrl against a      |
// |          scan-schedule reference model.                                  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_switch_debounce_ctrl;

  localparam int NUM_CH       = 4;
  localparam int TICK_DIV     = 8;
  localparam int STABLE_TICKS = 3;
  localparam int EVT_DEPTH    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] switch_in;
  logic [NUM_CH-1:0] switch_out;
  logic              event_valid;
  logic              event_ready;
  logic [1:0]        event_ch;
  logic              event_level;
  logic              overflow;
  logic              clear_overflow;

  switch_debounce_ctrl #(
    .NUM_CH       (NUM_CH),
    .TICK_DIV     (TICK_DIV),
    .STABLE_TICKS (STABLE_TICKS),
    .EVT_DEPTH    (EVT_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .switch_in      (switch_in),
    .switch_out     (switch_out),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_ch       (event_ch),
    .event_level    (event_level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: edge k (counted from reset) scans channel k%TICK_DIV once
  // k >= TICK_DIV, using the raw input seen two edges earlier.
  int                m_k;
  logic [NUM_CH-1:0] hist[$];
  int                m_q[$];
  logic [NUM_CH-1:0] m_out;
  int                m_cnt[NUM_CH];
  logic              m_ovf;
  int                mch;
  logic [NUM_CH-1:0] msmp;
  bit                mdrop;

  int pops = 0;
  int pop_log[$];

  always @(posedge clk) begin
    if (!reset && event_valid && event_ready) begin
      pops++;
      pop_log.push_back({event_ch, event_level});
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m_k = 0;
      hist.delete();
      m_q.delete();
      m_out = '0;
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
      m_ovf = 1'b0;
    end else begin
      hist.push_back(switch_in);
      if (hist.size() > 3) void'(hist.pop_front());
      if (event_ready && m_q.size() > 0) void'(m_q.pop_front());
      mdrop = 1'b0;
      if (m_k >= TICK_DIV && (m_k % TICK_DIV) < NUM_CH) begin
        mch  = m_k % TICK_DIV;
        msmp = (hist.size() == 3) ? hist[0] : '0;
        if (msmp[mch] == m_out[mch]) begin
          m_cnt[mch] = 0;
        end else begin
          m_cnt[mch]++;
          if (m_cnt[mch] == STABLE_TICKS) begin
            m_cnt[mch]  = 0;
            m_out[mch]  = msmp[mch];
            if (m_q.size() < EVT_DEPTH) m_q.push_back(mch * 2 + int'(msmp[mch]));
            else mdrop = 1'b1;
          end
        end
      end
      if (mdrop) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
      m_k++;
    end
  end

  // True when the coming edge will accept a change on the channel it scans.
  function automatic bit accept_next();
    int ch;
    logic [NUM_CH-1:0] s;
    if (m_k < TICK_DIV || hist.size() < 3) return 1'b0;
    ch = m_k % TICK_DIV;
    if (ch >= NUM_CH) return 1'b0;
    s = hist[1];
    return (s[ch] != m_out[ch]) && (m_cnt[ch] == STABLE_TICKS - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("switch_out", 32'(switch_out), 32'(m_out));
    chk("event_valid", 32'(event_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk("event_head", 32'({event_ch, event_level}), 32'(m_q[0]));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      check_model();
    end
  endtask

  int  base;
  bit  found;
  int  pct;
  int  bitsel;

  initial begin
    reset = 1'b1; switch_in = '0; event_ready = 1'b0; clear_overflow = 1'b0;
    step(3);
    chk("rst_switch_out", 32'(switch_out), 32'h0);
    chk("rst_valid", 32'(event_valid), 32'h0);
    chk("rst_head", 32'({event_ch, event_level}), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);

    // 1: ch2 held high from reset
    reset = 1'b0; switch_in = 4'b0100; event_ready = 1'b1; base = pops;
    step(50);
    chk("t1_out", 32'(switch_out), 32'h4);
    chk("t1_pops", 32'(pops - base), 32'd1);
    if (pops > base) chk("t1_evt", 32'(pop_log[base]), 32'd5);

    // 2: ch0 high 2 scans, low 1 scan, then high
    base = pops;
    switch_in = 4'b0101; step(16);
    switch_in = 4'b0100; step(8);
    chk("t2_out_mid", 32'(switch_out), 32'h4);
    chk("t2_pops_mid", 32'(pops - base), 32'd0);
    switch_in = 4'b0101; step(40);
    chk("t2_out", 32'(switch_out), 32'h5);
    chk("t2_pops", 32'(pops - base), 32'd1);
    if (pops > base) chk("t2_evt", 32'(pop_log[base]), 32'd1);

    // 3: ch1 and ch3 change together
    base = pops;
    switch_in = 4'b1111; step(40);
    chk("t3_pops", 32'(pops - base), 32'd2);
    if (pops - base >= 2) begin
      chk("t3_evt0", 32'(pop_log[base]), 32'd3);
      chk("t3_evt1", 32'(pop_log[base + 1]), 32'd7);
    end
    chk("t3_empty", 32'(event_valid), 32'h0);

    // 4: five changes with consumer stalled
    event_ready = 1'b0;
    switch_in = 4'b0000; step(40);
    switch_in = 4'b0001; step(40);
    chk("t4_overflow", 32'(overflow), 32'h1);
    chk("t4_out", 32'(switch_out), 32'h1);
    chk("t4_valid", 32'(event_valid), 32'h1);
    clear_overflow = 1'b1; step(1); clear_overflow = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'h0);

    // 5: push and pop in the same cycle on a full FIFO
    base = pops; found = 1'b0;
    switch_in = 4'b0011;
    for (int n = 0; n < 60 && !found; n++) begin
      if (accept_next()) found = 1'b1;
      else step(1);
    end
    chk("t5_accept_seen", 32'(found), 32'h1);
    event_ready = 1'b1; step(1); event_ready = 1'b0;
    chk("t5_pop1", 32'(pops - base), 32'd1);
    chk("t5_no_ovf", 32'(overflow), 32'h0);
    chk("t5_valid", 32'(event_valid), 32'h1);
    event_ready = 1'b1; step(10); event_ready = 1'b0;
    chk("t5_pops", 32'(pops - base), 32'd5);
    if (pops - base >= 5) begin
      chk("t5_evt0", 32'(pop_log[base]), 32'd0);
      chk("t5_evt1", 32'(pop_log[base + 1]), 32'd2);
      chk("t5_evt2", 32'(pop_log[base + 2]), 32'd4);
      chk("t5_evt3", 32'(pop_log[base + 3]), 32'd6);
      chk("t5_evt4", 32'(pop_log[base + 4]), 32'd3);
    end

    // 6: reset mid-scan with two queued events
    switch_in = 4'b0000; found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      if (m_q.size() == 2) found = 1'b1;
      else step(1);
    end
    chk("t6_two_queued", 32'(found), 32'h1);
    chk("t6_pre_valid", 32'(event_valid), 32'h1);
    reset = 1'b1; step(1);
    chk("t6_valid", 32'(event_valid), 32'h0);
    chk("t6_out", 32'(switch_out), 32'h0);
    chk("t6_overflow", 32'(overflow), 32'h0);
    reset = 1'b0; switch_in = 4'b0010; event_ready = 1'b1; base = pops;
    step(40);
    chk("t6_out_after", 32'(switch_out), 32'h2);
    chk("t6_pops", 32'(pops - base), 32'd1);
    if (pops > base) chk("t6_evt", 32'(pop_log[base]), 32'd3);

    // Random phase: bouncy inputs, varying consumer throughput, rare resets
    pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: pct = 0;
          1: pct = 10;
          2: pct = 50;
          default: pct = 100;
        endcase
      end
      if ($urandom_range(0, 15) == 0) begin
        bitsel = $urandom_range(0, NUM_CH - 1);
        switch_in[bitsel] = ~switch_in[bitsel];
      end
      event_ready    = ($urandom_range(0, 99) < pct);
      clear_overflow = ($urandom_range(0, 63) == 0);
      reset          = ($urandom_range(0, 1499) == 0);
      step(1);
    end
    reset = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
